// File: rtl/pong_pkg.sv
// Shared types and constants for the pong score keeper: FSM states and
// seven-segment digit codes ordered {g,f,e,d,c,b,a}, active-high.
package pong_pkg;

  typedef enum logic [1:0] {
    StPause = 2'd0,
    StPlay  = 2'd1,
    StOver  = 2'd2
  } state_e;

  typedef logic [6:0] seg_t;

  localparam seg_t Seg0     = 7'b0111111;
  localparam seg_t Seg1     = 7'b0000110;
  localparam seg_t Seg2     = 7'b1011011;
  localparam seg_t Seg3     = 7'b1001111;
  localparam seg_t Seg4     = 7'b1100110;
  localparam seg_t Seg5     = 7'b1101101;
  localparam seg_t Seg6     = 7'b1111101;
  localparam seg_t Seg7     = 7'b0000111;
  localparam seg_t Seg8     = 7'b1111111;
  localparam seg_t Seg9     = 7'b1101111;
  localparam seg_t SegBlank = 7'b0000000;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to seven-segment decode; values 10-15 blank the digit.
module seg7_decode
  import pong_pkg::*;
(
  input  logic [3:0] digit,
  output seg_t       seg
);

  always_comb begin
    seg = SegBlank;
    case (digit)
      4'd0:    seg = Seg0;
      4'd1:    seg = Seg1;
      4'd2:    seg = Seg2;
      4'd3:    seg = Seg3;
      4'd4:    seg = Seg4;
      4'd5:    seg = Seg5;
      4'd6:    seg = Seg6;
      4'd7:    seg = Seg7;
      4'd8:    seg = Seg8;
      4'd9:    seg = Seg9;
      default: seg = SegBlank;
    endcase
  end

endmodule

// File: rtl/score_keeper.sv
// Pong score keeper: counts goals, paces serves on frame ticks, detects the
// winner and drives registered seven-segment codes for both scores.
module score_keeper
  import pong_pkg::*;
#(
  parameter int unsigned WIN_SCORE    = 9,
  parameter int unsigned PAUSE_FRAMES = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       goal_l,
  input  logic       goal_r,
  input  logic       restart,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic [6:0] seg_l,
  output logic [6:0] seg_r,
  output logic       ball_en,
  output logic       serve,
  output logic       game_over,
  output logic       winner
);

  localparam logic [3:0] WinScore  = 4'(WIN_SCORE);
  localparam logic [7:0] PauseLast = 8'(PAUSE_FRAMES - 1);

  state_e     state_q, state_d;
  logic [7:0] pause_cnt_q, pause_cnt_d;
  logic [3:0] score_l_q, score_l_d, score_r_q, score_r_d;
  seg_t       seg_l_q, seg_l_d, seg_r_q, seg_r_d;
  logic       serve_q, serve_d;
  logic       game_over_q, game_over_d;
  logic       winner_q, winner_d;
  seg_t       dec_l, dec_r;

  seg7_decode u_dec_l (
    .digit (score_l_q),
    .seg   (dec_l)
  );

  seg7_decode u_dec_r (
    .digit (score_r_q),
    .seg   (dec_r)
  );

  always_comb begin
    state_d     = state_q;
    pause_cnt_d = pause_cnt_q;
    score_l_d   = score_l_q;
    score_r_d   = score_r_q;
    game_over_d = game_over_q;
    winner_d    = winner_q;
    serve_d     = 1'b0;
    // Decodes the current score, so segments trail the score by one cycle.
    seg_l_d     = dec_l;
    seg_r_d     = dec_r;

    if (restart) begin
      state_d     = StPause;
      pause_cnt_d = 8'd0;
      score_l_d   = 4'd0;
      score_r_d   = 4'd0;
      game_over_d = 1'b0;
      winner_d    = 1'b0;
    end else begin
      unique case (state_q)
        StPause: begin
          if (frame_tick) begin
            if (pause_cnt_q == PauseLast) begin
              state_d     = StPlay;
              serve_d     = 1'b1;
              pause_cnt_d = 8'd0;
            end else begin
              pause_cnt_d = pause_cnt_q + 8'd1;
            end
          end
        end
        StPlay: begin
          // Simultaneous goals are treated as a glitch and dropped.
          if (goal_l ^ goal_r) begin
            if (goal_l) score_l_d = score_l_q + 4'd1;
            else        score_r_d = score_r_q + 4'd1;
            if ((goal_l ? score_l_d : score_r_d) == WinScore) begin
              state_d     = StOver;
              game_over_d = 1'b1;
              winner_d    = goal_r;
            end else begin
              state_d     = StPause;
              pause_cnt_d = 8'd0;
            end
          end
        end
        StOver: ;
        default: state_d = StPause;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StPause;
      pause_cnt_q <= 8'd0;
      score_l_q   <= 4'd0;
      score_r_q   <= 4'd0;
      seg_l_q     <= Seg0;
      seg_r_q     <= Seg0;
      serve_q     <= 1'b0;
      game_over_q <= 1'b0;
      winner_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pause_cnt_q <= pause_cnt_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      seg_l_q     <= seg_l_d;
      seg_r_q     <= seg_r_d;
      serve_q     <= serve_d;
      game_over_q <= game_over_d;
      winner_q    <= winner_d;
    end
  end

  assign score_l   = score_l_q;
  assign score_r   = score_r_q;
  assign seg_l     = seg_l_q;
  assign seg_r     = seg_r_q;
  assign ball_en   = (state_q == StPlay);
  assign serve     = serve_q;
  assign game_over = game_over_q;
  assign winner    = winner_q;

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper (WIN_SCORE=3, PAUSE_FRAMES=2) using a
// cycle model that pushes expected outputs into a scoreboard queue.
module tb_score_keeper;

  // Stimulus encoding: {rst_n, restart, goal_l, goal_r, frame_tick}
  localparam logic [4:0] Idle = 5'b10000;
  localparam logic [4:0] Tk   = 5'b10001;
  localparam logic [4:0] Gl   = 5'b10100;
  localparam logic [4:0] Gr   = 5'b10010;
  localparam logic [4:0] Gb   = 5'b10110;
  localparam logic [4:0] Rs   = 5'b11000;
  localparam logic [4:0] RsGl = 5'b11100;
  localparam logic [4:0] Rst  = 5'b00000;

  typedef struct packed {
    logic [3:0] sl;
    logic [3:0] sr;
    logic [6:0] gl;
    logic [6:0] gr;
    logic       be;
    logic       sv;
    logic       go;
    logic       wn;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       goal_l = 1'b0;
  logic       goal_r = 1'b0;
  logic       restart = 1'b0;
  logic [3:0] score_l, score_r;
  logic [6:0] seg_l, seg_r;
  logic       ball_en, serve, game_over, winner;

  int total = 0;
  int bad = 0;
  obs_t sb[$];

  // Reference model state: 0 = pause, 1 = play, 2 = over.
  int         m_st = 0;
  int         m_cnt = 0;
  logic [3:0] m_sl = 4'd0, m_sr = 4'd0;
  logic [6:0] m_gl = 7'b0111111, m_gr = 7'b0111111;
  logic       m_sv = 1'b0, m_go = 1'b0, m_wn = 1'b0;

  score_keeper #(
    .WIN_SCORE    (3),
    .PAUSE_FRAMES (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .goal_l     (goal_l),
    .goal_r     (goal_r),
    .restart    (restart),
    .score_l    (score_l),
    .score_r    (score_r),
    .seg_l      (seg_l),
    .seg_r      (seg_r),
    .ball_en    (ball_en),
    .serve      (serve),
    .game_over  (game_over),
    .winner     (winner)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'b0111111;
      4'd1: return 7'b0000110;
      4'd2: return 7'b1011011;
      4'd3: return 7'b1001111;
      4'd4: return 7'b1100110;
      4'd5: return 7'b1101101;
      4'd6: return 7'b1111101;
      4'd7: return 7'b0000111;
      4'd8: return 7'b1111111;
      4'd9: return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic obs_t sample();
    return {score_l, score_r, seg_l, seg_r, ball_en, serve, game_over, winner};
  endfunction

  // Advance the model by one edge and record what the DUT should show after it.
  task automatic model_edge(input logic [4:0] v);
    logic [6:0] ngl, ngr;
    ngl  = seg_of(m_sl);
    ngr  = seg_of(m_sr);
    m_sv = 1'b0;
    if (!v[4]) begin
      m_st = 0; m_cnt = 0; m_sl = 4'd0; m_sr = 4'd0;
      m_go = 1'b0; m_wn = 1'b0;
      ngl = 7'b0111111; ngr = 7'b0111111;
    end else if (v[3]) begin
      m_st = 0; m_cnt = 0; m_sl = 4'd0; m_sr = 4'd0;
      m_go = 1'b0; m_wn = 1'b0;
    end else if (m_st == 0) begin
      if (v[0]) begin
        if (m_cnt == 1) begin
          m_st = 1; m_sv = 1'b1; m_cnt = 0;
        end else begin
          m_cnt++;
        end
      end
    end else if (m_st == 1 && (v[2] != v[1])) begin
      if (v[2]) m_sl++;
      else      m_sr++;
      if (m_sl == 4'd3 || m_sr == 4'd3) begin
        m_st = 2; m_go = 1'b1; m_wn = v[1];
      end else begin
        m_st = 0; m_cnt = 0;
      end
    end
    m_gl = ngl;
    m_gr = ngr;
    sb.push_back({m_sl, m_sr, m_gl, m_gr, (m_st == 1), m_sv, m_go, m_wn});
  endtask

  task automatic step(input logic [4:0] v);
    rst_n      = v[4];
    restart    = v[3];
    goal_l     = v[2];
    goal_r     = v[1];
    frame_tick = v[0];
    model_edge(v);
    @(posedge clk);
    #1;
    {rst_n, restart, goal_l, goal_r, frame_tick} = Idle;
  endtask

  task automatic test_reset();
    logic [4:0] tab [2] = '{Rst, Rst};
    obs_t exp, got;
    foreach (tab[i]) begin
      step(tab[i]);
      exp = sb.pop_front(); got = sample(); total++;
      if (got !== exp) begin
        bad++; $display("FAIL reset[%0d] got=%h want=%h", i, got, exp);
      end
    end
    total++;
    if ({seg_l, seg_r, ball_en, serve, game_over} !== {7'b0111111, 7'b0111111, 3'b000}) begin
      bad++; $display("FAIL reset_values seg_l=%b seg_r=%b be=%b sv=%b go=%b want 0111111/0",
                      seg_l, seg_r, ball_en, serve, game_over);
    end
  endtask

  task automatic test_serve();
    logic [4:0] tab [4] = '{Idle, Tk, Tk, Idle};
    obs_t exp, got;
    foreach (tab[i]) begin
      step(tab[i]);
      exp = sb.pop_front(); got = sample(); total++;
      if (got !== exp) begin
        bad++; $display("FAIL serve[%0d] got=%h want=%h", i, got, exp);
      end
      if (i == 2) begin
        total++;
        if ({serve, ball_en} !== 2'b11) begin
          bad++; $display("FAIL serve_pulse serve=%b ball_en=%b want 1 1", serve, ball_en);
        end
      end
    end
    total++;
    if ({serve, ball_en} !== 2'b01) begin
      bad++; $display("FAIL serve_one_cycle serve=%b ball_en=%b want 0 1", serve, ball_en);
    end
  endtask

  task automatic test_goal_r();
    logic [4:0] tab [2] = '{Gr, Idle};
    obs_t exp, got;
    foreach (tab[i]) begin
      step(tab[i]);
      exp = sb.pop_front(); got = sample(); total++;
      if (got !== exp) begin
        bad++; $display("FAIL goal_r[%0d] got=%h want=%h", i, got, exp);
      end
      if (i == 0) begin
        total++;
        if ({score_r, ball_en, seg_r} !== {4'd1, 1'b0, 7'b0111111}) begin
          bad++; $display("FAIL goal_r_score score_r=%0d be=%b seg_r=%b want 1 0 0111111",
                          score_r, ball_en, seg_r);
        end
      end
    end
    total++;
    if (seg_r !== 7'b0000110) begin
      bad++; $display("FAIL goal_r_seg seg_r=%b want 0000110", seg_r);
    end
  endtask

  task automatic test_ignore();
    logic [4:0] tab [7] = '{Tk, Tk, Gb, Gl, Gl, Tk, Tk};
    obs_t exp, got;
    foreach (tab[i]) begin
      step(tab[i]);
      exp = sb.pop_front(); got = sample(); total++;
      if (got !== exp) begin
        bad++; $display("FAIL ignore[%0d] got=%h want=%h", i, got, exp);
      end
      if (i == 2) begin
        total++;
        if ({score_l, score_r, ball_en} !== {4'd0, 4'd1, 1'b1}) begin
          bad++; $display("FAIL both_goals sl=%0d sr=%0d be=%b want 0 1 1",
                          score_l, score_r, ball_en);
        end
      end
      if (i == 4) begin
        total++;
        if ({score_l, ball_en} !== {4'd1, 1'b0}) begin
          bad++; $display("FAIL pause_goal sl=%0d be=%b want 1 0", score_l, ball_en);
        end
      end
    end
  endtask

  task automatic test_left_win();
    logic [4:0] tab [10] = '{Gl, Tk, Tk, Gl, Idle, Tk, Tk, Gl, Gr, Tk};
    obs_t exp, got;
    foreach (tab[i]) begin
      step(tab[i]);
      exp = sb.pop_front(); got = sample(); total++;
      if (got !== exp) begin
        bad++; $display("FAIL left_win[%0d] got=%h want=%h", i, got, exp);
      end
      if (i == 3) begin
        total++;
        if ({game_over, winner, score_l, ball_en} !== {1'b1, 1'b0, 4'd3, 1'b0}) begin
          bad++; $display("FAIL left_win_over go=%b wn=%b sl=%0d be=%b want 1 0 3 0",
                          game_over, winner, score_l, ball_en);
        end
      end
      if (i == 4) begin
        total++;
        if (seg_l !== 7'b1001111) begin
          bad++; $display("FAIL left_win_seg seg_l=%b want 1001111", seg_l);
        end
      end
    end
    total++;
    if ({game_over, score_l, score_r, ball_en, serve} !== {1'b1, 4'd3, 4'd1, 2'b00}) begin
      bad++; $display("FAIL over_hold go=%b sl=%0d sr=%0d be=%b sv=%b want 1 3 1 0 0",
                      game_over, score_l, score_r, ball_en, serve);
    end
  endtask

  task automatic test_restart_priority();
    logic [4:0] tab [14] = '{Rs, Tk, Tk, Gl, Tk, Tk, Gl, Tk, Tk, RsGl, Tk, Rst, Idle, Tk};
    obs_t exp, got;
    foreach (tab[i]) begin
      step(tab[i]);
      exp = sb.pop_front(); got = sample(); total++;
      if (got !== exp) begin
        bad++; $display("FAIL restart[%0d] got=%h want=%h", i, got, exp);
      end
      if (i == 9) begin
        total++;
        if ({score_l, ball_en, game_over} !== {4'd0, 1'b0, 1'b0}) begin
          bad++; $display("FAIL restart_prio sl=%0d be=%b go=%b want 0 0 0",
                          score_l, ball_en, game_over);
        end
      end
      if (i == 11) begin
        total++;
        if ({score_l, score_r, seg_l, seg_r, ball_en, serve, game_over, winner} !==
            {8'd0, 7'b0111111, 7'b0111111, 4'b0000}) begin
          bad++; $display("FAIL mid_pause_reset sl=%0d sr=%0d segl=%b segr=%b be=%b sv=%b",
                          score_l, score_r, seg_l, seg_r, ball_en, serve);
        end
      end
      if (i == 13) begin
        total++;
        if ({serve, ball_en} !== 2'b00) begin
          bad++; $display("FAIL reset_clears_count sv=%b be=%b want 0 0", serve, ball_en);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] tab [9] = '{Tk, Gr, Tk, Tk, Gr, Tk, Tk, Gr, Rs};
    obs_t exp, got;
    foreach (tab[i]) begin
      step(tab[i]);
      exp = sb.pop_front(); got = sample(); total++;
      if (got !== exp) begin
        bad++; $display("FAIL right_win[%0d] got=%h want=%h", i, got, exp);
      end
      if (i == 7) begin
        total++;
        if ({game_over, winner, score_r} !== {1'b1, 1'b1, 4'd3}) begin
          bad++; $display("FAIL right_win_over go=%b wn=%b sr=%0d want 1 1 3",
                          game_over, winner, score_r);
        end
      end
    end
    total++;
    if ({game_over, winner, score_r, ball_en} !== {2'b00, 4'd0, 1'b0}) begin
      bad++; $display("FAIL restart_from_over go=%b wn=%b sr=%0d be=%b want 0 0 0 0",
                      game_over, winner, score_r, ball_en);
    end
  endtask

  initial begin
    test_reset();
    test_serve();
    test_goal_r();
    test_ignore();
    test_left_win();
    test_restart_priority();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
